// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared state type, digit width and prescaler sizing for the game clock
package scoreboard_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_PEND,
    S_OVER
  } state_t;

  function automatic int presc_w(input int hz);
    return (hz > 1) ? $clog2(hz) : 1;
  endfunction

endpackage

// File: rtl/bcd_down_timer.sv
// rtl/bcd_down_timer.sv - four-digit BCD mm:ss down counter with load and zero detect
module bcd_down_timer
  import scoreboard_pkg::*;
#(
  parameter int PERIOD_MIN = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_dec,
  output logic [BCD_W-1:0] o_min_tens,
  output logic [BCD_W-1:0] o_min_ones,
  output logic [BCD_W-1:0] o_sec_tens,
  output logic [BCD_W-1:0] o_sec_ones,
  output logic             o_zero
);

  localparam logic [BCD_W-1:0] LD_MT = BCD_W'(PERIOD_MIN / 10);
  localparam logic [BCD_W-1:0] LD_MO = BCD_W'(PERIOD_MIN % 10);

  logic [BCD_W-1:0] r_mt, r_mo, r_st, r_so;

  assign o_zero     = (r_mt == '0) && (r_mo == '0) && (r_st == '0) && (r_so == '0);
  assign o_min_tens = r_mt;
  assign o_min_ones = r_mo;
  assign o_sec_tens = r_st;
  assign o_sec_ones = r_so;

  // Borrow ripples right to left; the zero guard keeps 00:00 sticky.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mt <= LD_MT;
      r_mo <= LD_MO;
      r_st <= '0;
      r_so <= '0;
    end else if (i_load) begin
      r_mt <= LD_MT;
      r_mo <= LD_MO;
      r_st <= '0;
      r_so <= '0;
    end else if (i_dec && !o_zero) begin
      if (r_so != '0) begin
        r_so <= r_so - 1'b1;
      end else begin
        r_so <= BCD_W'(9);
        if (r_st != '0) begin
          r_st <= r_st - 1'b1;
        end else begin
          r_st <= BCD_W'(5);
          if (r_mo != '0) begin
            r_mo <= r_mo - 1'b1;
          end else begin
            r_mo <= BCD_W'(9);
            r_mt <= r_mt - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/game_clock_ctrl.sv
// rtl/game_clock_ctrl.sv - period clock sequencer: run/pause FSM, prescaler, period count and horn
module game_clock_ctrl
  import scoreboard_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int PERIOD_MIN  = 12,
  parameter int NUM_PERIODS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] period,
  output logic       running,
  output logic       period_end,
  output logic       game_over,
  output logic       buzz
);

  localparam int            PW          = presc_w(CLK_HZ);
  localparam logic [PW-1:0] PRESC_MAX   = PW'(CLK_HZ - 1);
  localparam logic [2:0]    LAST_PERIOD = 3'(NUM_PERIODS);

  state_t        r_state, w_next;
  logic [PW-1:0] r_presc, r_buzz_cnt;
  logic [2:0]    r_period;
  logic          r_running, r_period_end, r_game_over, r_buzz;
  logic          w_tick, w_last_tick, w_reload, w_zero;

  bcd_down_timer #(.PERIOD_MIN(PERIOD_MIN)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_reload),
    .i_dec      (w_tick),
    .o_min_tens (min_tens),
    .o_min_ones (min_ones),
    .o_sec_tens (sec_tens),
    .o_sec_ones (sec_ones),
    .o_zero     (w_zero)
  );

  assign w_tick      = (r_state == S_RUN) && (r_presc == PRESC_MAX) && !w_zero;
  // The tick that turns 00:01 into 00:00 moves the FSM on the same edge as the digits.
  assign w_last_tick = w_tick && (min_tens == 4'd0) && (min_ones == 4'd0) &&
                       (sec_tens == 4'd0) && (sec_ones == 4'd1);
  assign w_reload    = (r_state == S_PEND) && start_stop;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_stop) w_next = S_RUN;
      S_RUN: begin
        if (w_last_tick)     w_next = (r_period < LAST_PERIOD) ? S_PEND : S_OVER;
        else if (start_stop) w_next = S_PAUSE;
      end
      S_PAUSE: if (start_stop) w_next = S_RUN;
      S_PEND:  if (start_stop) w_next = S_RUN;
      S_OVER:  w_next = S_OVER;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_running    <= 1'b0;
      r_game_over  <= 1'b0;
      r_period_end <= 1'b0;
      r_period     <= 3'd1;
    end else begin
      r_state      <= w_next;
      r_running    <= (w_next == S_RUN);
      r_game_over  <= (w_next == S_OVER);
      r_period_end <= w_last_tick;
      if (w_reload) r_period <= r_period + 3'd1;
    end
  end

  // PAUSE holds the count so a resumed second keeps its elapsed fraction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
    end else if (r_state == S_RUN) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end else if (r_state != S_PAUSE) begin
      r_presc <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buzz     <= 1'b0;
      r_buzz_cnt <= '0;
    end else if (w_last_tick) begin
      r_buzz     <= 1'b1;
      r_buzz_cnt <= PRESC_MAX;
    end else if (r_buzz) begin
      if (r_buzz_cnt == '0) r_buzz <= 1'b0;
      else                  r_buzz_cnt <= r_buzz_cnt - 1'b1;
    end
  end

  assign period     = r_period;
  assign running    = r_running;
  assign period_end = r_period_end;
  assign game_over  = r_game_over;
  assign buzz       = r_buzz;

endmodule

// File: tb/tb_game_clock_ctrl.sv
// tb/tb_game_clock_ctrl.sv - scoreboard bench: expected output changes queued by stimulus, checked by monitor
module tb_game_clock_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_stop;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [2:0] period;
  logic       running, period_end, game_over, buzz;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         cyc;
    logic [3:0] mt, mo, st, so;
    logic [2:0] per;
    logic       run, pe, go, bz;
  } snap_t;

  snap_t exp_q[$];

  int   m_secs;
  int   m_per;
  logic m_run, m_pe, m_go, m_bz;

  game_clock_ctrl #(.CLK_HZ(4), .PERIOD_MIN(1), .NUM_PERIODS(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .period     (period),
    .running    (running),
    .period_end (period_end),
    .game_over  (game_over),
    .buzz       (buzz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic snap_t model_snap(input int c);
    snap_t s;
    int mins, secs;
    mins  = m_secs / 60;
    secs  = m_secs % 60;
    s.cyc = c;
    s.mt  = 4'(mins / 10);
    s.mo  = 4'(mins % 10);
    s.st  = 4'(secs / 10);
    s.so  = 4'(secs % 10);
    s.per = 3'(m_per);
    s.run = m_run;
    s.pe  = m_pe;
    s.go  = m_go;
    s.bz  = m_bz;
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.cyc = cyc;
    s.mt  = min_tens;
    s.mo  = min_ones;
    s.st  = sec_tens;
    s.so  = sec_ones;
    s.per = period;
    s.run = running;
    s.pe  = period_end;
    s.go  = game_over;
    s.bz  = buzz;
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("%0d%0d:%0d%0d p=%0d run=%0b pe=%0b go=%0b bz=%0b cyc=%0d",
                     s.mt, s.mo, s.st, s.so, s.per, s.run, s.pe, s.go, s.bz, s.cyc);
  endfunction

  function automatic bit differs(input snap_t a, input snap_t b);
    return (a.mt !== b.mt) || (a.mo !== b.mo) || (a.st !== b.st) || (a.so !== b.so) ||
           (a.per !== b.per) || (a.run !== b.run) || (a.pe !== b.pe) ||
           (a.go !== b.go) || (a.bz !== b.bz);
  endfunction

  task automatic model_reset();
    m_secs = 60; m_per = 1; m_run = 1'b0; m_pe = 1'b0; m_go = 1'b0; m_bz = 1'b0;
  endtask

  task automatic expect_at(input int c);
    exp_q.push_back(model_snap(c));
  endtask

  task automatic check(input snap_t got);
    snap_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_change: got %s, want no change", fmt(got));
    end else begin
      e = exp_q.pop_front();
      if (differs(got, e) || (got.cyc != e.cyc)) begin
        n_bad++;
        $display("FAIL output_change: got %s, want %s", fmt(got), fmt(e));
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse();
    start_stop = 1'b1;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
  endtask

  initial begin : monitor
    snap_t prev, cur;
    #3;
    prev = dut_snap();
    check(prev);
    forever begin
      @(negedge clk or negedge reset);
      #1;
      cur = dut_snap();
      if (differs(cur, prev)) check(cur);
      prev = cur;
    end
  end

  initial begin : stim
    int e0, r, e1, e2, e3;
    reset      = 1'b1;
    start_stop = 1'b0;
    model_reset();
    expect_at(0);
    #1 reset = 1'b0;
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(20);

    e0 = cyc + 1; m_run = 1'b1; expect_at(e0);
    pulse();
    for (int k = 1; k <= 11; k++) begin m_secs = 60 - k; expect_at(e0 + 4 * k); end

    // Pause with two counts already in the prescaler, then resume.
    wait_until(e0 + 45);
    m_run = 1'b0; expect_at(e0 + 46);
    pulse();
    wait_until(e0 + 146);
    r = cyc + 1; m_run = 1'b1; expect_at(r);
    pulse();
    for (int k = 0; k <= 47; k++) begin m_secs = 48 - k; expect_at(r + 2 + 4 * k); end

    e1 = r + 194;
    m_secs = 0; m_pe = 1'b1; m_bz = 1'b1; m_run = 1'b0; expect_at(e1);
    m_pe = 1'b0; expect_at(e1 + 1);
    wait_until(e1 + 1);
    m_secs = 60; m_per = 2; m_run = 1'b1; expect_at(e1 + 2);
    pulse();
    m_bz = 1'b0; expect_at(e1 + 4);
    for (int k = 1; k <= 59; k++) begin m_secs = 60 - k; expect_at(e1 + 2 + 4 * k); end

    e2 = e1 + 242;
    m_secs = 0; m_pe = 1'b1; m_bz = 1'b1; m_run = 1'b0; m_go = 1'b1; expect_at(e2);
    m_pe = 1'b0; expect_at(e2 + 1);
    m_bz = 1'b0; expect_at(e2 + 4);
    wait_until(e2 - 1);
    pulse();
    wait_until(e2 + 6);
    repeat (3) begin
      pulse();
      wait_cycles(2);
    end
    wait_cycles(5);

    #1;
    model_reset(); expect_at(cyc);
    reset = 1'b0;
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(2);

    e3 = cyc + 1; m_run = 1'b1; expect_at(e3);
    pulse();
    for (int k = 1; k <= 23; k++) begin m_secs = 60 - k; expect_at(e3 + 4 * k); end
    wait_until(e3 + 94);
    #1;
    model_reset(); expect_at(cyc);
    reset = 1'b0;
    wait_cycles(4);
    reset = 1'b1;
    wait_cycles(4);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_changes: got %0d unconsumed, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
